// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states and
// the default operand width.
package muldiv_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath on unsigned magnitudes. Sequenced entirely by
// muldiv_unit; MULDIV_EARLY_TERM_EN enables the "multiplier exhausted" status flag.
module muldiv_datapath #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc,
  output logic              mul_last
);

  // acc_q: product accumulator (mul) or {remainder, quotient} (div).
  // sreg_q: multiplicand shifted left each step (mul) or divisor in the low half (div).
  logic [2*XLEN-1:0] acc_q, acc_d, sreg_q, sreg_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN:0]     sh_rem;
  logic [XLEN-1:0]   diff;
  logic              ge;

  always_comb begin
    acc_d    = acc_q;
    sreg_d   = sreg_q;
    mplier_d = mplier_q;
    sh_rem   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge       = sh_rem >= {1'b0, sreg_q[XLEN-1:0]};
    // Only taken when ge, so the true difference always fits in XLEN bits.
    diff     = sh_rem[XLEN-1:0] - sreg_q[XLEN-1:0];
    if (load) begin
      mplier_d = op_b;
      if (is_div) begin
        acc_d  = {{XLEN{1'b0}}, op_a};
        sreg_d = {{XLEN{1'b0}}, op_b};
      end else begin
        acc_d  = '0;
        sreg_d = {{XLEN{1'b0}}, op_a};
      end
    end else if (step) begin
      if (is_div) begin
        if (ge) acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
        else    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
        if (mplier_q[0]) acc_d = acc_q + sreg_q;
        sreg_d   = sreg_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      sreg_q   <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      sreg_q   <= sreg_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc = acc_q;

`ifdef MULDIV_EARLY_TERM_EN
  // True when the step in progress consumes the last set multiplier bit.
  assign mul_last = (mplier_q[XLEN-1:1] == '0);
`else
  assign mul_last = 1'b0;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: FSM, iteration counter and sign fix-up around
// muldiv_datapath. Optional MULDIV_EARLY_TERM_EN ends multiplies once the multiplier is spent.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDefault,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d, div_q, div_d;

  logic              is_mul_op, is_div_op, is_signed_op, accept;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic              dp_load, dp_step, dp_is_div, mul_last, last_iter;
  logic [2*XLEN-1:0] acc;

  assign is_mul_op    = (op_code == OpMult) || (op_code == OpMultu);
  assign is_div_op    = (op_code == OpDiv) || (op_code == OpDivu);
  assign is_signed_op = (op_code == OpMult) || (op_code == OpDiv);
  assign accept       = op_valid && (state_q == StIdle);

  assign a_mag = (is_signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
  assign b_mag = (is_signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;

  assign dp_load   = accept && (is_mul_op || is_div_op);
  assign dp_step   = (state_q == StMul) || (state_q == StDiv);
  assign dp_is_div = (state_q == StIdle) ? is_div_op : (state_q == StDiv);
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  assign quo = acc[XLEN-1:0];
  assign rem = acc[2*XLEN-1:XLEN];

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (dp_load),
    .step    (dp_step),
    .is_div  (dp_is_div),
    .op_a    (a_mag),
    .op_b    (b_mag),
    .acc     (acc),
    .mul_last(mul_last)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    div_d     = div_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op_code)
            OpMult, OpMultu: begin
              state_d = StMul;
              cnt_d   = '0;
              div_d   = 1'b0;
              neg_d   = is_signed_op && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            end
            OpDiv, OpDivu: begin
              state_d   = StDiv;
              cnt_d     = '0;
              div_d     = 1'b1;
              neg_d     = is_signed_op && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
              rem_neg_d = is_signed_op && rs_data[XLEN-1];
              dz_d      = (rt_data == '0);
            end
            OpMthi:  hi_d = rs_data;
            OpMtlo:  lo_d = rs_data;
            default: ;
          endcase
        end
      end
      StMul: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter || mul_last) state_d = StFix;
      end
      StDiv: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (div_q) begin
          // Divide-by-zero keeps an all-ones quotient regardless of operand signs.
          lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
          hi_d = rem_neg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q ? -acc : acc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      div_q     <= div_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops checked against
// an arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .op_valid(op_valid),
    .op_code (op_code),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {hi, lo} after an op, straight from the architectural definition.
  function automatic logic [63:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
    int     sa, sb, q, r;
    longint sp;
    sa = a;
    sb = b;
    case (op)
      OpMult: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      OpMultu: return {32'b0, a} * {32'b0, b};
      OpDiv: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      OpDivu: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OpMthi:  return {a, cur_lo};
      OpMtlo:  return {cur_hi, a};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  // Edges from accept to the done edge.
  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int          k;
    if (op == OpMult || op == OpMultu) begin
      m = (op == OpMult && b[31]) ? -b : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      return k + 2;
    end
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] r;
    int          lat;
    bit          busy_ok, vis_ok, multi;
    r       = model_op(op, a, b, exp_hi, exp_lo);
    multi   = (op >= OpMult) && (op <= OpDivu);
    busy_ok = 1'b1;
    vis_ok  = 1'b1;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = OpNop;
    if (!multi) begin
      check_eq("single_busy", busy, 0);
      check_eq("single_done", done, 0);
      check_eq("single_hi", hi, r[63:32]);
      check_eq("single_lo", lo, r[31:0]);
    end else begin
      lat = 0;
      while (!done && lat < 40) begin
        if (!busy) busy_ok = 1'b0;
        if (hi !== exp_hi || lo !== exp_lo) vis_ok = 1'b0;
        if (inject && lat == 3) begin
          op_valid = 1'b1;
          op_code  = OpMtlo;
          rs_data  = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        lat++;
      end
      op_valid = 1'b0;
      op_code  = OpNop;
      check_eq("latency", lat, exp_latency(op, b));
      check_eq("done_seen", done, 1);
      check_eq("busy_during_op", busy_ok, 1);
      check_eq("hilo_hold", vis_ok, 1);
      check_eq("busy_at_done", busy, 0);
      check_eq("res_hi", hi, r[63:32]);
      check_eq("res_lo", lo, r[31:0]);
      @(posedge clk);
      #1;
      check_eq("done_one_pulse", done, 0);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = OpNop;
    rs_data  = '0;
    rt_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hi", hi, 0);
    check_eq("reset_lo", lo, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OpMult, 32'hFFFF_FFF9, 32'd6, 1'b0);
    run_op(OpMult, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(OpDiv, 32'hFFFF_FFEF, 32'd5, 1'b0);
    run_op(OpDivu, 32'd100, 32'd7, 1'b0);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OpDivu, 32'h1234, 32'h0, 1'b0);
    run_op(OpDiv, 32'hFFFF_FF00, 32'h0, 1'b0);
    run_op(OpMthi, 32'hAAAA_5555, 32'h0, 1'b0);
    run_op(OpMultu, 32'h0001_0003, 32'h0000_0105, 1'b1);
    run_op(OpMultu, 32'h1357_9BDF, 32'h1, 1'b0);

    // Reset ten cycles into a divide.
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OpDiv;
    rs_data  = 32'hFFFF_FFEF;
    rt_data  = 32'd5;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = OpNop;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(OpMultu, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
